// File: rtl/mem_bus_bridge_if.sv
// Core data-port and external req/ack bus bundle around mem_bus_bridge.
// master = the bridge itself; slave = the core and external memory facing it.
interface mem_bus_bridge_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          core_ren;
    logic          core_wen;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;

    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    modport master (
        input  core_ren, core_wen, core_addr, core_wdata, bus_ack, bus_rdata,
        output core_rdata, core_stall, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output core_ren, core_wen, core_addr, core_wdata, bus_ack, bus_rdata,
        input  core_rdata, core_stall, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Data-memory bridge: zero-wait local MMIO (LED, cycle counter, status) and
// external accesses over a req/ack bus guarded by a timeout watchdog.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_bridge_if.master mbus,
    output logic [15:0]      led,
    output logic             bus_err
);
    localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [5:0]    OFS_LED  = 6'd0;
    localparam logic [5:0]    OFS_CYC  = 6'd1;
    localparam logic [5:0]    OFS_STAT = 6'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   cycle_cnt;
    logic [31:0]   rdata_q;
    logic          bus_req_q, bus_we_q;
    logic [31:0]   bus_addr_q, bus_wdata_q;

    logic          access, is_local;
    logic [5:0]    offset;
    logic [31:0]   local_rdata;
    logic [31:0]   core_rdata_c;
    logic          core_stall_c;
    logic          start, ack_take, tmo_hit, local_we;
    logic          unused_addr_lsb;

    // Held in reset the core cannot be stalled, even if its request lines linger.
    assign access   = rst_n & (mbus.core_ren | mbus.core_wen);
    assign is_local = (mbus.core_addr[31:8] == 24'hFFFFFF);
    assign offset   = mbus.core_addr[7:2];
    assign unused_addr_lsb = ^mbus.core_addr[1:0];

    // Local register read mux
    always_comb begin
        local_rdata = 32'h0;
        case (offset)
            OFS_LED:  local_rdata = {16'h0, led};
            OFS_CYC:  local_rdata = cycle_cnt;
            OFS_STAT: local_rdata = {31'h0, bus_err};
            default:  local_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall and read-data steering
    always_comb begin
        state_d      = state_q;
        core_stall_c = 1'b0;
        core_rdata_c = 32'h0;
        start        = 1'b0;
        ack_take     = 1'b0;
        tmo_hit      = 1'b0;
        local_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (is_local) begin
                        core_rdata_c = local_rdata;
                        local_we     = mbus.core_wen;
                    end else begin
                        core_stall_c = 1'b1;
                        start        = 1'b1;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                core_stall_c = 1'b1;
                if (mbus.bus_ack) begin
                    ack_take = 1'b1;
                    state_d  = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                core_rdata_c = bus_we_q ? 32'h0 : rdata_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // External request launch, hold, completion capture and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            tmo_cnt     <= '0;
            rdata_q     <= 32'h0;
        end else begin
            if (start) begin
                bus_req_q   <= 1'b1;
                bus_we_q    <= mbus.core_wen;
                bus_addr_q  <= {mbus.core_addr[31:2], 2'b00};
                bus_wdata_q <= mbus.core_wdata;
                tmo_cnt     <= '0;
            end
            if (ack_take || tmo_hit) begin
                bus_req_q <= 1'b0;
                tmo_cnt   <= '0;
            end else if (state_q == REQ) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (ack_take && !bus_we_q) begin
                rdata_q <= mbus.bus_rdata;
            end
            if (tmo_hit) begin
                rdata_q <= ERR_DATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // MMIO registers; a timeout set beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= 16'h0;
            bus_err <= 1'b0;
        end else begin
            if (local_we && offset == OFS_LED) begin
                led <= mbus.core_wdata[15:0];
            end
            if (tmo_hit) begin
                bus_err <= 1'b1;
            end else if (local_we && offset == OFS_STAT && mbus.core_wdata[0]) begin
                bus_err <= 1'b0;
            end
        end
    end

    assign mbus.core_rdata = core_rdata_c;
    assign mbus.core_stall = core_stall_c;
    assign mbus.bus_req    = bus_req_q;
    assign mbus.bus_we     = bus_we_q;
    assign mbus.bus_addr   = bus_addr_q;
    assign mbus.bus_wdata  = bus_wdata_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: directed scenarios plus randomized accesses against
// a transaction-level model (register values, external memory, latency rules).
module tb_mem_bus_bridge;
    localparam int unsigned TIMEOUT  = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
    localparam logic [31:0] A_LED    = 32'hFFFFFF00;
    localparam logic [31:0] A_CYC    = 32'hFFFFFF04;
    localparam logic [31:0] A_STAT   = 32'hFFFFFF08;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] led;
    logic        bus_err;
    int          checks  = 0;
    int          passed  = 0;
    int          n_edges = 0;

    // Reference model state
    logic [15:0] led_m    = 16'h0;
    logic        err_m    = 1'b0;
    logic [31:0] cyc_base = 32'h0;
    int          cyc_t0   = 0;
    logic [31:0] ext_mem [logic [29:0]];

    mem_bus_bridge_if mif ();

    mem_bus_bridge #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mbus    (mif),
        .led     (led),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) n_edges <= n_edges + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] cyc_exp();
        return cyc_base + 32'(n_edges - cyc_t0);
    endfunction

    function automatic logic [31:0] local_read(input logic [31:0] addr);
        logic [5:0] w;
        w = addr[7:2];
        case (w)
            6'd0:    return {16'h0, led_m};
            6'd1:    return cyc_exp();
            6'd2:    return {31'h0, err_m};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_local_write(input logic [31:0] addr, input logic [31:0] wdata);
        if (addr[7:2] == 6'd0) led_m = wdata[15:0];
        if (addr[7:2] == 6'd2 && wdata[0]) err_m = 1'b0;
    endtask

    // Core + slave driver: presents one access, acks on REQ cycle ack_at (0 = never).
    task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at, input logic [31:0] ack_data,
                          output logic [31:0] rdata, output int stalls, output int req_cycles,
                          output logic bus_ok);
        int guard;
        guard = 0;
        @(negedge clk);
        mif.core_ren = ren; mif.core_wen = wen; mif.core_addr = addr; mif.core_wdata = wdata;
        #1;
        stalls = 0; req_cycles = 0; bus_ok = 1'b1;
        while (mif.core_stall === 1'b1 && guard < 64) begin
            stalls++; guard++;
            if (mif.bus_req === 1'b1) begin
                req_cycles++;
                if (mif.bus_addr !== {addr[31:2], 2'b00} || mif.bus_we !== wen ||
                    (wen && mif.bus_wdata !== wdata)) bus_ok = 1'b0;
                if (req_cycles == ack_at) begin
                    mif.bus_ack = 1'b1; mif.bus_rdata = ack_data;
                end
            end
            @(negedge clk);
            mif.bus_ack = 1'b0; mif.bus_rdata = $urandom;
            #1;
        end
        if (mif.bus_req !== 1'b0) bus_ok = 1'b0;
        rdata = mif.core_rdata;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mif.core_ren = 1'b0; mif.core_wen = 1'b0; mif.core_addr = $urandom;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int st, rq; logic ok;
        rst_n = 1'b0;
        mif.core_ren = 1'b0; mif.core_wen = 1'b0; mif.core_addr = 32'h0; mif.core_wdata = 32'h0;
        mif.bus_ack = 1'b0; mif.bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({mif.bus_req, mif.bus_we, mif.core_stall, bus_err} !== 4'b0)
            $display("FAIL reset_ctrl: req/we/stall/err=%b want 0000",
                     {mif.bus_req, mif.bus_we, mif.core_stall, bus_err}); else passed++;
        checks++; if (mif.bus_addr !== 32'h0 || mif.bus_wdata !== 32'h0)
            $display("FAIL reset_bus: addr=%h wdata=%h want 0", mif.bus_addr, mif.bus_wdata); else passed++;
        checks++; if (led !== 16'h0) $display("FAIL reset_led: got %h want 0000", led); else passed++;
        checks++; if (mif.core_rdata !== 32'h0)
            $display("FAIL reset_rdata: got %h want 0", mif.core_rdata); else passed++;
        @(negedge clk);
        rst_n = 1'b1; cyc_base = 32'h0; cyc_t0 = n_edges; led_m = 16'h0; err_m = 1'b0;
        access(1'b1, 1'b0, A_CYC, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (rd !== cyc_exp()) $display("FAIL cycle_start: got %h want %h", rd, cyc_exp()); else passed++;
    endtask

    task automatic test_led();
        logic [31:0] rd; int st, rq; logic ok;
        access(1'b0, 1'b1, A_LED, 32'h0000A5A5, 0, 32'h0, rd, st, rq, ok);
        checks++; if (st !== 0 || !ok) $display("FAIL led_write_stall: stalls=%0d bus_ok=%0b want 0/1", st, ok); else passed++;
        led_m = 16'hA5A5;
        access(1'b1, 1'b0, A_LED, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (led !== 16'hA5A5) $display("FAIL led_reg: got %h want a5a5", led); else passed++;
        checks++; if (rd !== 32'h0000A5A5 || st !== 0 || !ok)
            $display("FAIL led_read: got %h stalls=%0d bus_ok=%0b want 0000a5a5/0/1", rd, st, ok); else passed++;
        access(1'b0, 1'b1, A_LED + 32'h3, 32'hFFFF1234, 0, 32'h0, rd, st, rq, ok);
        led_m = 16'h1234;
        access(1'b1, 1'b0, A_LED, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (rd !== 32'h00001234) $display("FAIL led_upper_zero: got %h want 00001234", rd); else passed++;
    endtask

    task automatic test_ext_read();
        logic [31:0] rd; int st, rq; logic ok;
        access(1'b1, 1'b0, 32'h00000104, 32'h0, 3, 32'h12345678, rd, st, rq, ok);
        checks++; if (st !== 4 || rq !== 3) $display("FAIL ext_read_lat: stalls=%0d req=%0d want 4/3", st, rq); else passed++;
        checks++; if (!ok) $display("FAIL ext_read_bus: addr=%h we=%b want 00000104/0", mif.bus_addr, mif.bus_we); else passed++;
        checks++; if (rd !== 32'h12345678) $display("FAIL ext_read_data: got %h want 12345678", rd); else passed++;
        idle_cycle();
        checks++; if (mif.core_rdata !== 32'h0 || mif.core_stall !== 1'b0)
            $display("FAIL ext_read_idle: rdata=%h stall=%b want 0/0", mif.core_rdata, mif.core_stall); else passed++;
        access(1'b1, 1'b0, 32'h00000108, 32'h0, 1, 32'h0F0F0F0F, rd, st, rq, ok);
        checks++; if (st !== 2 || rd !== 32'h0F0F0F0F)
            $display("FAIL ext_min_lat: stalls=%0d data=%h want 2/0f0f0f0f", st, rd); else passed++;
    endtask

    task automatic test_ext_write();
        logic [31:0] rd; int st, rq; logic ok;
        access(1'b1, 1'b1, 32'h00000203, 32'hCAFEF00D, 2, 32'h11111111, rd, st, rq, ok);
        checks++; if (!ok || mif.bus_addr !== 32'h00000200 || mif.bus_we !== 1'b1 || mif.bus_wdata !== 32'hCAFEF00D)
            $display("FAIL ext_write_bus: addr=%h we=%b wdata=%h want 00000200/1/cafef00d",
                     mif.bus_addr, mif.bus_we, mif.bus_wdata); else passed++;
        checks++; if (st !== 3 || rd !== 32'h0) $display("FAIL ext_write_done: stalls=%0d rdata=%h want 3/0", st, rd); else passed++;
    endtask

    task automatic test_timeout();
        logic [31:0] rd; int st, rq; logic ok;
        access(1'b1, 1'b0, 32'h00000300, 32'h0, TIMEOUT, 32'h0BADF00D, rd, st, rq, ok);
        checks++; if (st !== TIMEOUT + 1 || rd !== 32'h0BADF00D || bus_err !== 1'b0)
            $display("FAIL ack_wins: stalls=%0d data=%h err=%b want %0d/0badf00d/0", st, rd, bus_err, TIMEOUT + 1); else passed++;
        access(1'b1, 1'b0, 32'h00000300, 32'h0, 0, 32'h0, rd, st, rq, ok);
        err_m = 1'b1;
        checks++; if (rq !== TIMEOUT || st !== TIMEOUT + 1 || !ok)
            $display("FAIL tmo_len: req=%0d stalls=%0d bus_ok=%0b want %0d/%0d/1", rq, st, ok, TIMEOUT, TIMEOUT + 1); else passed++;
        checks++; if (rd !== ERR_DATA) $display("FAIL tmo_data: got %h want %h", rd, ERR_DATA); else passed++;
        checks++; if (bus_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", bus_err); else passed++;
        access(1'b1, 1'b0, A_STAT, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (rd !== 32'h1) $display("FAIL stat_read: got %h want 00000001", rd); else passed++;
        access(1'b0, 1'b1, A_STAT, 32'hFFFFFFFE, 0, 32'h0, rd, st, rq, ok);
        idle_cycle();
        checks++; if (bus_err !== 1'b1) $display("FAIL stat_keep: got %b want 1", bus_err); else passed++;
        access(1'b0, 1'b1, A_STAT, 32'h00000001, 0, 32'h0, rd, st, rq, ok);
        err_m = 1'b0;
        access(1'b1, 1'b0, A_STAT, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (rd !== 32'h0 || bus_err !== 1'b0) $display("FAIL stat_clear: rd=%h err=%b want 0/0", rd, bus_err); else passed++;
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] rd; int st, rq; logic ok;
        access(1'b1, 1'b0, 32'h00000500, 32'h0, 0, 32'h0, rd, st, rq, ok);
        err_m = 1'b1;
        @(negedge clk);
        mif.core_ren = 1'b1; mif.core_wen = 1'b0; mif.core_addr = 32'h00000600;
        @(negedge clk); #1;
        checks++; if (mif.bus_req !== 1'b1 || bus_err !== 1'b1)
            $display("FAIL rst_pre: req=%b err=%b want 1/1", mif.bus_req, bus_err); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({mif.bus_req, mif.core_stall, bus_err} !== 3'b000)
            $display("FAIL rst_async: req/stall/err=%b want 000", {mif.bus_req, mif.core_stall, bus_err}); else passed++;
        checks++; if (led !== 16'h0) $display("FAIL rst_led: got %h want 0000", led); else passed++;
        @(negedge clk);
        mif.core_ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; cyc_base = 32'h0; cyc_t0 = n_edges; led_m = 16'h0; err_m = 1'b0;
        #1;
        mif.bus_ack = 1'b1; mif.bus_rdata = 32'h77777777;
        @(negedge clk);
        mif.bus_ack = 1'b0;
        #1;
        checks++; if ({mif.bus_req, mif.core_stall} !== 2'b00 || mif.core_rdata !== 32'h0)
            $display("FAIL late_ack: req/stall=%b rdata=%h want 00/0", {mif.bus_req, mif.core_stall}, mif.core_rdata); else passed++;
        access(1'b1, 1'b0, 32'h00000600, 32'h0, 1, 32'h600D600D, rd, st, rq, ok);
        checks++; if (st !== 2 || rd !== 32'h600D600D || !ok)
            $display("FAIL rst_idle: stalls=%0d data=%h bus_ok=%0b want 2/600d600d/1", st, rd, ok); else passed++;
    endtask

    task automatic test_cycle_counter();
        logic [31:0] rd; int st, rq; logic ok;
        access(1'b1, 1'b0, A_CYC, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (rd !== cyc_exp()) $display("FAIL cyc_count: got %h want %h", rd, cyc_exp()); else passed++;
        @(negedge clk);
        mif.core_ren = 1'b1; mif.core_wen = 1'b0; mif.core_addr = A_CYC;
        force dut.cycle_cnt = 32'hFFFFFFFE;
        #1;
        release dut.cycle_cnt;
        cyc_base = 32'hFFFFFFFE; cyc_t0 = n_edges;
        #1;
        checks++; if (mif.core_rdata !== 32'hFFFFFFFE) $display("FAIL cyc_preload: got %h want fffffffe", mif.core_rdata); else passed++;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mif.core_rdata !== cyc_exp()) $display("FAIL cyc_wrap: got %h want %h", mif.core_rdata, cyc_exp()); else passed++;
        access(1'b0, 1'b1, A_CYC, 32'h12345678, 0, 32'h0, rd, st, rq, ok);
        access(1'b1, 1'b0, A_CYC, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (rd !== cyc_exp()) $display("FAIL cyc_ro: got %h want %h", rd, cyc_exp()); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int st, rq; logic ok;
        access(1'b0, 1'b1, 32'h00000040, 32'hA0A0A0A0, 1, 32'h0, rd, st, rq, ok);
        checks++; if (st !== 2 || !ok) $display("FAIL b2b_write: stalls=%0d bus_ok=%0b want 2/1", st, ok); else passed++;
        access(1'b1, 1'b0, 32'h00000044, 32'h0, 2, 32'h000055AA, rd, st, rq, ok);
        checks++; if (st !== 3 || rd !== 32'h000055AA || !ok)
            $display("FAIL b2b_read: stalls=%0d data=%h want 3/000055aa", st, rd); else passed++;
        access(1'b0, 1'b1, A_LED, 32'h00001111, 0, 32'h0, rd, st, rq, ok);
        led_m = 16'h1111;
        access(1'b1, 1'b0, A_LED, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (st !== 0 || rd !== 32'h00001111) $display("FAIL b2b_local: stalls=%0d data=%h want 0/00001111", st, rd); else passed++;
        access(1'b1, 1'b0, A_LED + 32'h0C, 32'h0, 0, 32'h0, rd, st, rq, ok);
        checks++; if (rd !== 32'h0 || !ok) $display("FAIL unmapped: got %h want 0", rd); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, ack_data, exp_rd;
        logic        ren, wen, is_loc, ok, acked;
        int          st, rq, ack_at, exp_st;
        for (int i = 0; i < 80; i++) begin
            is_loc = ($urandom_range(0, 2) == 0);
            ren = 1'($urandom_range(0, 1));
            wen = 1'($urandom_range(0, 1));
            if (!wen) ren = 1'b1;
            if (is_loc) addr = {24'hFFFFFF, 4'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            else        addr = {20'h0, 12'($urandom)};
            wdata  = $urandom;
            ack_at = $urandom_range(0, TIMEOUT + 1);
            acked  = (ack_at >= 1) && (ack_at <= TIMEOUT);
            if (!is_loc && !ext_mem.exists(addr[31:2])) ext_mem[addr[31:2]] = $urandom;
            ack_data = (wen || is_loc) ? 32'($urandom) : ext_mem[addr[31:2]];
            access(ren, wen, addr, wdata, ack_at, ack_data, rd, st, rq, ok);
            if (is_loc) begin
                exp_st = 0;
                exp_rd = wen ? 32'h0 : local_read(addr);
            end else begin
                exp_st = acked ? ack_at + 1 : TIMEOUT + 1;
                exp_rd = wen ? 32'h0 : (acked ? ack_data : ERR_DATA);
                if (!acked) err_m = 1'b1;
                else if (wen) ext_mem[addr[31:2]] = wdata;
            end
            checks++; if (st !== exp_st || !ok)
                $display("FAIL rnd_stall[%0d]: addr=%h stalls=%0d bus_ok=%0b want %0d/1", i, addr, st, ok, exp_st); else passed++;
            if (!(is_loc && wen)) begin
                checks++; if (rd !== exp_rd) $display("FAIL rnd_data[%0d]: addr=%h got %h want %h", i, addr, rd, exp_rd); else passed++;
            end
            checks++; if (bus_err !== err_m || led !== led_m)
                $display("FAIL rnd_regs[%0d]: err=%b led=%h want %b/%h", i, bus_err, led, err_m, led_m); else passed++;
            if (is_loc && wen) model_local_write(addr, wdata);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_led();
        test_ext_read();
        test_ext_write();
        test_timeout();
        test_reset_mid_req();
        test_cycle_counter();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
